// File: rtl/mp_cache_tag_pkg.sv
// ============================================================================
// mp_cache_tag_pkg
// Shared widths and enumerations for the cache tag SRAM controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mp_cache_tag_pkg;

    localparam int TAG_WIDTH = 24;
    localparam int IDX_WIDTH = 4;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } tag_ctrl_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LK   = 2'd1,
        GNT_UP   = 2'd2
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/mp_cache_tag_arb.sv
// ============================================================================
// mp_cache_tag_arb
// Combinational lookup/update grant for the tag SRAM port.
// Build option MP_TAG_CTRL_RR_EN selects round-robin instead of update priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mp_cache_tag_arb
    import mp_cache_tag_pkg::*;
(
`ifdef MP_TAG_CTRL_RR_EN
    input  logic   clk,
    input  logic   rst,
`endif
    input  logic   en,
    input  logic   lk_valid,
    input  logic   up_valid,
    output logic   lk_ready,
    output logic   up_ready,
    output grant_t grant
);

`ifdef MP_TAG_CTRL_RR_EN
    // 1 = update was granted last; reset state says lookup went last.
    logic r_last_up;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_up <= 1'b0;
        end else if (grant == GNT_UP) begin
            r_last_up <= 1'b1;
        end else if (grant == GNT_LK) begin
            r_last_up <= 1'b0;
        end
    end

    always_comb begin
        up_ready = en && (!lk_valid || !r_last_up);
        lk_ready = en && (!up_valid ||  r_last_up);
    end
`else
    always_comb begin
        up_ready = en;
        lk_ready = en && !up_valid;
    end
`endif

    always_comb begin
        grant = GNT_NONE;
        if (up_valid && up_ready) begin
            grant = GNT_UP;
        end else if (lk_valid && lk_ready) begin
            grant = GNT_LK;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mp_cache_tag_ctrl.sv
// ============================================================================
// mp_cache_tag_ctrl
// Tag SRAM port sequencer: post-reset clear sweep, then lookup/update service.
// Build option MP_TAG_CTRL_RR_EN enables round-robin arbitration.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mp_cache_tag_ctrl
    import mp_cache_tag_pkg::*;
#(
    parameter int                   TAG_WIDTH  = mp_cache_tag_pkg::TAG_WIDTH,
    parameter int                   IDX_WIDTH  = mp_cache_tag_pkg::IDX_WIDTH,
    parameter logic [TAG_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lk_valid,
    input  logic [IDX_WIDTH-1:0] lk_idx,
    output logic                 lk_ready,
    output logic                 lk_rvalid,
    output logic [TAG_WIDTH-1:0] lk_rdata,
    input  logic                 up_valid,
    input  logic [IDX_WIDTH-1:0] up_idx,
    input  logic [TAG_WIDTH-1:0] up_data,
    output logic                 up_ready,
    output logic                 init_done,
    output logic                 sram_csb,
    output logic                 sram_web,
    output logic [IDX_WIDTH-1:0] sram_addr,
    output logic [TAG_WIDTH-1:0] sram_din,
    input  logic [TAG_WIDTH-1:0] sram_dout
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = {IDX_WIDTH{1'b1}};

    tag_ctrl_state_t      r_state, w_state_nxt;
    logic [IDX_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                 r_init_done, w_init_done_nxt;
    logic                 r_lk_rvalid;
    logic [IDX_WIDTH-1:0] r_addr_last;
    logic [TAG_WIDTH-1:0] r_din_last;
    grant_t               w_grant;

    mp_cache_tag_arb u_arb (
`ifdef MP_TAG_CTRL_RR_EN
        .clk      (clk),
        .rst      (rst),
`endif
        .en       (r_state == RUN),
        .lk_valid (lk_valid),
        .up_valid (up_valid),
        .lk_ready (lk_ready),
        .up_ready (up_ready),
        .grant    (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_lk_rvalid <= 1'b0;
            r_addr_last <= '0;
            r_din_last  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= w_init_done_nxt;
            r_lk_rvalid <= (w_grant == GNT_LK);
            r_addr_last <= sram_addr;
            r_din_last  <= sram_din;
        end
    end

    // Address/data hold their last driven values whenever the port is idle.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_init_done_nxt = r_init_done;
        sram_csb        = 1'b1;
        sram_web        = 1'b1;
        sram_addr       = r_addr_last;
        sram_din        = r_din_last;
        case (r_state)
            INIT: begin
                // Keep the macro deselected while reset is still held.
                if (!rst) begin
                    sram_csb  = 1'b0;
                    sram_web  = 1'b0;
                    sram_addr = r_cnt;
                    sram_din  = INIT_VALUE;
                end
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt     = RUN;
                    w_init_done_nxt = 1'b1;
                end
            end
            RUN: begin
                case (w_grant)
                    GNT_UP: begin
                        sram_csb  = 1'b0;
                        sram_web  = 1'b0;
                        sram_addr = up_idx;
                        sram_din  = up_data;
                    end
                    GNT_LK: begin
                        sram_csb  = 1'b0;
                        sram_addr = lk_idx;
                    end
                    default: ;
                endcase
            end
            default: w_state_nxt = INIT;
        endcase
    end

    assign init_done = r_init_done;
    assign lk_rvalid = r_lk_rvalid;
    assign lk_rdata  = sram_dout;

endmodule

`default_nettype wire

// File: tb/tb_mp_cache_tag_ctrl.sv
// ============================================================================
// tb_mp_cache_tag_ctrl
// Directed self-checking bench with a behavioural 16x24 tag SRAM behind the controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mp_cache_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lk_valid = 1'b0;
    logic [3:0]  lk_idx = '0;
    logic        lk_ready, lk_rvalid;
    logic [23:0] lk_rdata;
    logic        up_valid = 1'b0;
    logic [3:0]  up_idx = '0;
    logic [23:0] up_data = '0;
    logic        up_ready, init_done;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_addr;
    logic [23:0] sram_din, sram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mp_cache_tag_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .lk_valid  (lk_valid),
        .lk_idx    (lk_idx),
        .lk_ready  (lk_ready),
        .lk_rvalid (lk_rvalid),
        .lk_rdata  (lk_rdata),
        .up_valid  (up_valid),
        .up_idx    (up_idx),
        .up_data   (up_data),
        .up_ready  (up_ready),
        .init_done (init_done),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    // Tag macro: inputs registered while selected, write commits one edge later,
    // read data is the array word at the registered address.
    logic [23:0] mem [16];
    logic        m_csb = 1'b1;
    logic        m_web = 1'b1;
    logic [3:0]  m_addr = '0;
    logic [23:0] m_din = '0;
    bit          seeded = 1'b0;

    always @(posedge clk) begin
        if (rst && !seeded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 24'hBAD000 + 24'(i);
            seeded <= 1'b1;
        end else if (!m_csb && !m_web) begin
            mem[m_addr] <= m_din;
        end
        if (!sram_csb) begin
            m_csb  <= sram_csb;
            m_web  <= sram_web;
            m_addr <= sram_addr;
            m_din  <= sram_din;
        end
    end

    assign sram_dout = mem[m_addr];

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({init_done, lk_rvalid, lk_ready, up_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b exp 0000", {init_done, lk_rvalid, lk_ready, up_ready});
        end
        n_checks++;
        if ({sram_csb, sram_web, sram_addr, sram_din} !== {1'b1, 1'b1, 4'h0, 24'h0}) begin
            n_fail++;
            $display("FAIL reset_sram: got csb=%b web=%b addr=%h din=%h exp 1 1 0 0",
                     sram_csb, sram_web, sram_addr, sram_din);
        end
    endtask

    task automatic test_sweep;
        @(negedge clk);
        rst = 1'b0;
        lk_valid = 1'b1; up_valid = 1'b1; up_data = 24'hFFFFFF; up_idx = 4'h9; lk_idx = 4'h6;
        for (int k = 0; k < 16; k++) begin
            #1;
            n_checks++;
            if ({sram_csb, sram_web, sram_addr, sram_din, lk_ready, up_ready, init_done} !==
                {1'b0, 1'b0, 4'(k), 24'h0, 3'b000}) begin
                n_fail++;
                $display("FAIL sweep_%0d: got csb=%b web=%b addr=%h din=%h lkr=%b upr=%b done=%b exp 0 0 %h 0 0 0 0",
                         k, sram_csb, sram_web, sram_addr, sram_din, lk_ready, up_ready, init_done, k);
            end
            @(negedge clk);
        end
        lk_valid = 1'b0; up_valid = 1'b0;
        #1;
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done_cycle17: got %b exp 1", init_done);
        end
    endtask

    task automatic test_lookup_after_init;
        @(negedge clk);
        lk_valid = 1'b1; lk_idx = 4'd5;
        #1;
        n_checks++;
        if ({lk_ready, sram_csb, sram_web, sram_addr} !== {1'b1, 1'b0, 1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL lookup5_grant: got rdy=%b csb=%b web=%b addr=%h exp 1 0 1 5",
                     lk_ready, sram_csb, sram_web, sram_addr);
        end
        @(negedge clk);
        lk_valid = 1'b0;
        #1;
        n_checks++;
        if ({lk_rvalid, lk_rdata} !== {1'b1, 24'h000000}) begin
            n_fail++;
            $display("FAIL lookup5_data: got rvalid=%b data=%h exp 1 000000", lk_rvalid, lk_rdata);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({lk_rvalid, sram_csb, sram_addr} !== {1'b0, 1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL idle_hold: got rvalid=%b csb=%b addr=%h exp 0 1 5", lk_rvalid, sram_csb, sram_addr);
        end
    endtask

    task automatic test_update_then_lookup;
        @(negedge clk);
        up_valid = 1'b1; up_idx = 4'd3; up_data = 24'hABCDEF;
        #1;
        n_checks++;
        if ({up_ready, sram_csb, sram_web, sram_addr, sram_din} !== {1'b1, 1'b0, 1'b0, 4'd3, 24'hABCDEF}) begin
            n_fail++;
            $display("FAIL upd3_grant: got rdy=%b csb=%b web=%b addr=%h din=%h exp 1 0 0 3 abcdef",
                     up_ready, sram_csb, sram_web, sram_addr, sram_din);
        end
        @(negedge clk);
        up_valid = 1'b0; lk_valid = 1'b1; lk_idx = 4'd3;
        #1;
        n_checks++;
        if (lk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lk3_ready: got %b exp 1", lk_ready);
        end
        @(negedge clk);
        lk_valid = 1'b0;
        #1;
        n_checks++;
        if ({lk_rvalid, lk_rdata} !== {1'b1, 24'hABCDEF}) begin
            n_fail++;
            $display("FAIL raw_hazard: got rvalid=%b data=%h exp 1 abcdef", lk_rvalid, lk_rdata);
        end
    endtask

    task automatic test_collision;
        @(negedge clk);
        lk_valid = 1'b1; lk_idx = 4'd7; up_valid = 1'b1; up_idx = 4'd7; up_data = 24'h123456;
        #1;
        n_checks++;
        if ({up_ready, lk_ready, sram_web, sram_addr} !== {1'b1, 1'b0, 1'b0, 4'd7}) begin
            n_fail++;
            $display("FAIL collide_first: got upr=%b lkr=%b web=%b addr=%h exp 1 0 0 7",
                     up_ready, lk_ready, sram_web, sram_addr);
        end
        @(negedge clk);
        up_valid = 1'b0;
        #1;
        n_checks++;
        if ({lk_ready, sram_web, sram_addr, lk_rvalid} !== {1'b1, 1'b1, 4'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL collide_second: got lkr=%b web=%b addr=%h rvalid=%b exp 1 1 7 0",
                     lk_ready, sram_web, sram_addr, lk_rvalid);
        end
        @(negedge clk);
        lk_valid = 1'b0;
        #1;
        n_checks++;
        if ({lk_rvalid, lk_rdata} !== {1'b1, 24'h123456}) begin
            n_fail++;
            $display("FAIL collide_data: got rvalid=%b data=%h exp 1 123456", lk_rvalid, lk_rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] vals [3];
        vals[0] = 24'h000011; vals[1] = 24'h000022; vals[2] = 24'h000033;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            up_valid = 1'b1; up_idx = 4'(i); up_data = vals[i];
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            up_valid = 1'b0;
            lk_valid = (i < 3); lk_idx = 4'(i);
            #1;
            if (i > 0) begin
                n_checks++;
                if ({lk_rvalid, lk_rdata} !== {1'b1, vals[i-1]}) begin
                    n_fail++;
                    $display("FAIL burst_%0d: got rvalid=%b data=%h exp 1 %h", i - 1, lk_rvalid, lk_rdata, vals[i-1]);
                end
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (lk_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_end: got rvalid=%b exp 0", lk_rvalid);
        end
    endtask

    // Both requesters held for six cycles; the last grant before this was a lookup.
    task automatic test_contention;
        logic [1:0] exp_rdy;
        @(negedge clk);
        lk_valid = 1'b1; lk_idx = 4'd8; up_valid = 1'b1; up_idx = 4'd8; up_data = 24'h00C0DE;
        for (int c = 0; c < 6; c++) begin
`ifdef MP_TAG_CTRL_RR_EN
            exp_rdy = (c % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_rdy = 2'b10;
`endif
            #1;
            n_checks++;
            if ({up_ready, lk_ready} !== exp_rdy) begin
                n_fail++;
                $display("FAIL contend_%0d: got upr,lkr=%b exp %b", c, {up_ready, lk_ready}, exp_rdy);
            end
            @(negedge clk);
        end
        lk_valid = 1'b0; up_valid = 1'b0;
    endtask

    task automatic test_reset_midsweep;
        @(negedge clk);
        up_valid = 1'b1; up_idx = 4'd12; up_data = 24'h5A5A5A;
        @(negedge clk);
        up_valid = 1'b0; lk_valid = 1'b1; lk_idx = 4'd12;
        @(posedge clk);
        #2;
        rst = 1'b1;
        lk_valid = 1'b0;
        #1;
        n_checks++;
        if ({lk_rvalid, sram_csb, init_done} !== 3'b010) begin
            n_fail++;
            $display("FAIL async_abort: got rvalid=%b csb=%b done=%b exp 0 1 0", lk_rvalid, sram_csb, init_done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++;
            if (sram_addr !== 4'(k)) begin
                n_fail++;
                $display("FAIL presweep_%0d: got addr=%h exp %h", k, sram_addr, k);
            end
            if (k < 9) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            n_checks++;
            if ({sram_csb, sram_addr, lk_rvalid, init_done} !== {1'b0, 4'(k), 2'b00}) begin
                n_fail++;
                $display("FAIL resweep_%0d: got csb=%b addr=%h rvalid=%b done=%b exp 0 %h 0 0",
                         k, sram_csb, sram_addr, lk_rvalid, init_done, k);
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL resweep_done: got %b exp 1", init_done);
        end
        @(negedge clk);
        lk_valid = 1'b1; lk_idx = 4'd12;
        @(negedge clk);
        lk_valid = 1'b0;
        #1;
        n_checks++;
        if ({lk_rvalid, lk_rdata} !== {1'b1, 24'h000000}) begin
            n_fail++;
            $display("FAIL resweep_clear: got rvalid=%b data=%h exp 1 000000", lk_rvalid, lk_rdata);
        end
    endtask

    initial begin
        test_reset;
        test_sweep;
        test_lookup_after_init;
        test_update_then_lookup;
        test_collision;
        test_back_to_back;
        test_contention;
        test_reset_midsweep;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
